// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, body field offsets and queue entry type for branch_resolve_unit.
// Optional BRANCH_STATS_EN build adds the taken/not-taken counter width use.
package branch_resolve_unit_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned MAJ_W    = 64;
  localparam int unsigned PID_W    = 20;
  localparam int unsigned TID_W    = 16;
  localparam int unsigned OPC_W    = 12;
  localparam int unsigned FU_W     = 3;
  localparam int unsigned CR_W     = 32;
  localparam int unsigned BODY_W   = 28;
  localparam int unsigned STAT_W   = 32;
  localparam int unsigned REG_SIZE = 5;
  localparam int unsigned IMM_SIZE = 14;

  localparam logic [FU_W-1:0] BRANCH_UNIT_ID = FU_W'(6);

  // Body bit 0 is the MSB, so BO[0:4] lives at vector bits 27..23
  localparam int unsigned BO_LSB = 23;
  localparam int unsigned BI_LSB = 18;
  localparam int unsigned BD_LSB = 4;
  localparam int unsigned AA_BIT = 3;
  localparam int unsigned LK_BIT = 2;

  typedef struct packed {
    logic [OPC_W-1:0]    opcode;
    logic [ADDR_W-1:0]   cia;
    logic [MAJ_W-1:0]    maj_id;
    logic                is64;
    logic [PID_W-1:0]    pid;
    logic [TID_W-1:0]    tid;
    logic [REG_SIZE-1:0] bo;
    logic [REG_SIZE-1:0] bi;
    logic [IMM_SIZE-1:0] bd;
    logic                aa;
    logic                lk;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decoder-facing and resolved-record signals of branch_resolve_unit.
// BRANCH_STATS_EN adds the two statistics counters.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;

  logic                enable_i;
  logic                stall_i;
  logic                flush_i;
  logic [OPC_W-1:0]    opcode_i;
  logic [FU_W-1:0]     functionalUnitType_i;
  logic [ADDR_W-1:0]   instructionAddress_i;
  logic [MAJ_W-1:0]    instMajId_i;
  logic                is64Bit_i;
  logic [PID_W-1:0]    instPid_i;
  logic [TID_W-1:0]    instTid_i;
  logic [BODY_W-1:0]   instructionBody_i;
  logic [CR_W-1:0]     cr_i;
  logic                ctrWrite_i;
  logic [ADDR_W-1:0]   ctrWriteData_i;

  logic                full_o;
  logic                enable_o;
  logic [OPC_W-1:0]    opcode_o;
  logic                taken_o;
  logic [ADDR_W-1:0]   targetAddress_o;
  logic                lrWrite_o;
  logic [ADDR_W-1:0]   lrData_o;
  logic [ADDR_W-1:0]   ctr_o;
  logic [MAJ_W-1:0]    instMajId_o;
  logic [PID_W-1:0]    instPid_o;
  logic [TID_W-1:0]    instTid_o;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0]   takenCount_o;
  logic [STAT_W-1:0]   notTakenCount_o;
`endif

  modport master (
    output enable_i, stall_i, flush_i, opcode_i, functionalUnitType_i,
           instructionAddress_i, instMajId_i, is64Bit_i, instPid_i, instTid_i,
           instructionBody_i, cr_i, ctrWrite_i, ctrWriteData_i,
    input  full_o, enable_o, opcode_o, taken_o, targetAddress_o, lrWrite_o,
           lrData_o, ctr_o, instMajId_o, instPid_o, instTid_o
`ifdef BRANCH_STATS_EN
    , input takenCount_o, notTakenCount_o
`endif
  );

  modport slave (
    input  enable_i, stall_i, flush_i, opcode_i, functionalUnitType_i,
           instructionAddress_i, instMajId_i, is64Bit_i, instPid_i, instTid_i,
           instructionBody_i, cr_i, ctrWrite_i, ctrWriteData_i,
    output full_o, enable_o, opcode_o, taken_o, targetAddress_o, lrWrite_o,
           lrData_o, ctr_o, instMajId_o, instPid_o, instTid_o
`ifdef BRANCH_STATS_EN
    , output takenCount_o, notTakenCount_o
`endif
  );

endinterface

// File: rtl/branch_resolve_unit_branch_fifo.sv
// Parameterised circular queue with wrap-bit pointers, combinational full/empty
// and a synchronous flush that discards all entries.
module branch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full queue can still take a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only pointed-to entries are ever read as valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Queues decoded B-form branches, resolves BO/BI against CR and CTR, and emits
// a registered resolved-branch record. Optional macro: BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clock_i,
  input logic               reset_i,
  branch_resolve_unit_if.slave bus
);

  br_entry_t         in_entry;
  br_entry_t         head;
  br_entry_t         s1;
  logic              s1_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              s1_adv;
  logic [ADDR_W-1:0] ctr;
  logic              unused_bits;

  logic [ADDR_W-1:0] ctr_src;
  logic [ADDR_W-1:0] ctr_next;
  logic [ADDR_W-1:0] ext;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] lr_data_c;
  logic              ctr_ok;
  logic              cond_ok;
  logic              taken_c;

  logic              out_enable;
  logic [OPC_W-1:0]  out_opcode;
  logic              out_taken;
  logic [ADDR_W-1:0] out_target;
  logic              out_lr_write;
  logic [ADDR_W-1:0] out_lr_data;
  logic [MAJ_W-1:0]  out_maj_id;
  logic [PID_W-1:0]  out_pid;
  logic [TID_W-1:0]  out_tid;

  assign in_entry = '{
    opcode: bus.opcode_i,
    cia:    bus.instructionAddress_i,
    maj_id: bus.instMajId_i,
    is64:   bus.is64Bit_i,
    pid:    bus.instPid_i,
    tid:    bus.instTid_i,
    bo:     bus.instructionBody_i[BO_LSB +: REG_SIZE],
    bi:     bus.instructionBody_i[BI_LSB +: REG_SIZE],
    bd:     bus.instructionBody_i[BD_LSB +: IMM_SIZE],
    aa:     bus.instructionBody_i[AA_BIT],
    lk:     bus.instructionBody_i[LK_BIT]
  };
  // Reserved body bits and the BO hint bit carry no meaning here
  assign unused_bits = ^{bus.instructionBody_i[1:0], s1.bo[0]};

  assign push   = bus.enable_i & ~fifo_full & ~bus.flush_i &
                  (bus.functionalUnitType_i == BRANCH_UNIT_ID);
  assign s1_adv = s1_valid & ~bus.stall_i & ~bus.flush_i;
  assign pop    = ~fifo_empty & ~bus.stall_i & ~bus.flush_i;

  branch_fifo #(
    .WIDTH ($bits(br_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_i),
    .flush (bus.flush_i),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage 1 holds the branch being evaluated
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
    end else if (!bus.stall_i) begin
      s1_valid <= pop;
      if (pop) s1 <= head;
    end
  end

  // BO[k] maps to bo[4-k]; a same-cycle CTR write becomes the decrement operand
  always_comb begin
    ctr_src   = bus.ctrWrite_i ? bus.ctrWriteData_i : ctr;
    ctr_next  = s1.bo[2] ? ctr_src : ctr_src - ADDR_W'(1);
    ctr_ok    = s1.bo[2] | ((s1.is64 ? (|ctr_next) : (|ctr_next[31:0])) ^ s1.bo[1]);
    cond_ok   = s1.bo[4] | (bus.cr_i[~s1.bi] == s1.bo[3]);
    taken_c   = ctr_ok & cond_ok;
    ext       = {{(ADDR_W-IMM_SIZE-2){s1.bd[IMM_SIZE-1]}}, s1.bd, 2'b00};
    seq_addr  = s1.cia + ADDR_W'(4);
    target_c  = seq_addr;
    lr_data_c = seq_addr;
    if (taken_c) target_c = s1.aa ? ext : s1.cia + ext;
    if (!s1.is64) begin
      target_c[ADDR_W-1:32]  = '0;
      lr_data_c[ADDR_W-1:32] = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)                   ctr <= '0;
    else if (s1_adv && !s1.bo[2])   ctr <= ctr_next;
    else if (bus.ctrWrite_i)        ctr <= bus.ctrWriteData_i;
  end

  // Stage 2 is the registered resolved-branch record
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      out_enable   <= 1'b0;
      out_opcode   <= '0;
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_lr_write <= 1'b0;
      out_lr_data  <= '0;
      out_maj_id   <= '0;
      out_pid      <= '0;
      out_tid      <= '0;
    end else if (bus.flush_i) begin
      out_enable   <= 1'b0;
      out_lr_write <= 1'b0;
    end else if (!bus.stall_i) begin
      out_enable   <= s1_valid;
      out_lr_write <= s1_valid & s1.lk;
      if (s1_valid) begin
        out_opcode  <= s1.opcode;
        out_taken   <= taken_c;
        out_target  <= target_c;
        out_lr_data <= lr_data_c;
        out_maj_id  <= s1.maj_id;
        out_pid     <= s1.pid;
        out_tid     <= s1.tid;
      end
    end
  end

  assign bus.full_o          = fifo_full;
  assign bus.enable_o        = out_enable;
  assign bus.opcode_o        = out_opcode;
  assign bus.taken_o         = out_taken;
  assign bus.targetAddress_o = out_target;
  assign bus.lrWrite_o       = out_lr_write;
  assign bus.lrData_o        = out_lr_data;
  assign bus.ctr_o           = ctr;
  assign bus.instMajId_o     = out_maj_id;
  assign bus.instPid_o       = out_pid;
  assign bus.instTid_o       = out_tid;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt;
  logic [STAT_W-1:0] not_taken_cnt;

  // Saturating counters; survive flush, cleared only by reset
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (out_enable && !bus.stall_i) begin
      if (out_taken && !(&taken_cnt))          taken_cnt     <= taken_cnt + STAT_W'(1);
      if (!out_taken && !(&not_taken_cnt))     not_taken_cnt <= not_taken_cnt + STAT_W'(1);
    end
  end

  assign bus.takenCount_o    = taken_cnt;
  assign bus.notTakenCount_o = not_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: latency, CTR/CR
// conditions, backpressure, flush, 32-bit mode and asynchronous reset.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  branch_resolve_unit_if bus ();

  branch_resolve_unit dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] mk_body(input logic [4:0] bo, input logic [4:0] bi,
                                          input logic [13:0] bd, input logic aa,
                                          input logic lk);
    return {bo, bi, bd, aa, lk, 2'b00};
  endfunction

  task automatic drive_push(input logic [63:0] cia, input logic [27:0] body,
                            input logic [63:0] maj);
    bus.enable_i             = 1'b1;
    bus.functionalUnitType_i = BRANCH_UNIT_ID;
    bus.instructionAddress_i = cia;
    bus.instructionBody_i    = body;
    bus.instMajId_i          = maj;
  endtask

  task automatic idle();
    bus.enable_i = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n = 1'b0;
    bus.enable_i = 1'b0;  bus.stall_i = 1'b0;  bus.flush_i = 1'b0;
    bus.opcode_i = 12'h0A5;  bus.functionalUnitType_i = BRANCH_UNIT_ID;
    bus.instructionAddress_i = '0;  bus.instMajId_i = '0;  bus.is64Bit_i = 1'b1;
    bus.instPid_i = 20'h12345;  bus.instTid_i = 16'hBEEF;  bus.instructionBody_i = '0;
    bus.cr_i = '0;  bus.ctrWrite_i = 1'b0;  bus.ctrWriteData_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", bus.enable_o, 0);
    chk("rst_full", bus.full_o, 0);
    chk("rst_ctr", bus.ctr_o, 0);
    chk("rst_target", bus.targetAddress_o, 0);
    rst_n = 1'b1;
    step();

    // Unconditional relative bcl, latency two edges
    drive_push(64'h1000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b1), 64'd100);
    step();
    idle();
    step();
    chk("bcl_lat1", bus.enable_o, 0);
    step();
    chk("bcl_enable", bus.enable_o, 1);
    chk("bcl_taken", bus.taken_o, 1);
    chk("bcl_target", bus.targetAddress_o, 64'h1010);
    chk("bcl_lrwrite", bus.lrWrite_o, 1);
    chk("bcl_lrdata", bus.lrData_o, 64'h1004);
    chk("bcl_ctr", bus.ctr_o, 0);
    chk("bcl_majid", bus.instMajId_o, 100);
    chk("bcl_pid", bus.instPid_o, 20'h12345);
    chk("bcl_tid", bus.instTid_o, 16'hBEEF);
    chk("bcl_opcode", bus.opcode_o, 12'h0A5);
    step();
    chk("bcl_done", bus.enable_o, 0);

    // bdnz loop with CTR=2
    bus.ctrWrite_i = 1'b1;  bus.ctrWriteData_i = 64'd2;
    step();
    bus.ctrWrite_i = 1'b0;
    chk("ctr_load", bus.ctr_o, 2);
    drive_push(64'h2000, mk_body(5'b10000, 5'd0, 14'h3FFF, 1'b0, 1'b0), 64'd101);
    step(); idle(); step(); step();
    chk("bdnz1_taken", bus.taken_o, 1);
    chk("bdnz1_target", bus.targetAddress_o, 64'h1FFC);
    chk("bdnz1_ctr", bus.ctr_o, 1);
    chk("bdnz1_lrwrite", bus.lrWrite_o, 0);
    drive_push(64'h2000, mk_body(5'b10000, 5'd0, 14'h3FFF, 1'b0, 1'b0), 64'd102);
    step(); idle(); step(); step();
    chk("bdnz2_enable", bus.enable_o, 1);
    chk("bdnz2_taken", bus.taken_o, 0);
    chk("bdnz2_target", bus.targetAddress_o, 64'h2004);
    chk("bdnz2_ctr", bus.ctr_o, 0);

    // CR condition, absolute target
    bus.cr_i = 32'h2000_0000;
    drive_push(64'h3000, mk_body(5'b01100, 5'd2, 14'h003C, 1'b1, 1'b0), 64'd103);
    step(); idle(); step(); step();
    chk("cr1_taken", bus.taken_o, 1);
    chk("cr1_target", bus.targetAddress_o, 64'h00F0);
    bus.cr_i = 32'h0;
    drive_push(64'h3000, mk_body(5'b01100, 5'd2, 14'h003C, 1'b1, 1'b0), 64'd104);
    step(); idle(); step(); step();
    chk("cr0_taken", bus.taken_o, 0);
    chk("cr0_target", bus.targetAddress_o, 64'h3004);

    // Wrong functional-unit code is dropped
    drive_push(64'h4000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd105);
    bus.functionalUnitType_i = 3'd5;
    step(); idle(); step(); step();
    chk("fu_drop", bus.enable_o, 0);
    bus.functionalUnitType_i = BRANCH_UNIT_ID;

    // Backpressure: fill under stall, fifth push rejected
    bus.stall_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_push(64'h5000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'(i));
      step();
    end
    chk("bp_full", bus.full_o, 1);
    drive_push(64'h5000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd5);
    step();
    chk("bp_full_hold", bus.full_o, 1);
    idle();
    bus.stall_i = 1'b0;
    step();
    chk("bp_lat", bus.enable_o, 0);
    chk("bp_not_full", bus.full_o, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("bp_enable", bus.enable_o, 1);
      chk("bp_order", bus.instMajId_o, 64'(i));
    end
    step();
    chk("bp_fifth_dropped", bus.enable_o, 0);

    // Flush with three queued and one in S1
    drive_push(64'h6000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd20);
    step();
    drive_push(64'h6000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd21);
    step();
    bus.stall_i = 1'b1;
    drive_push(64'h6000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd22);
    step();
    drive_push(64'h6000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd23);
    step();
    chk("fl_pre_enable", bus.enable_o, 0);
    bus.flush_i = 1'b1;
    drive_push(64'h6000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0), 64'd24);
    step();
    bus.flush_i = 1'b0;  bus.stall_i = 1'b0;
    idle();
    chk("fl_full", bus.full_o, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fl_quiet", bus.enable_o, 0);
    end

    // 32-bit mode wrap after flush
    bus.is64Bit_i = 1'b0;
    drive_push(64'hFFFF_FFFC, mk_body(5'b10100, 5'd0, 14'h0001, 1'b0, 1'b0), 64'd30);
    step(); idle(); step();
    chk("m32_lat1", bus.enable_o, 0);
    step();
    chk("m32_enable", bus.enable_o, 1);
    chk("m32_taken", bus.taken_o, 1);
    chk("m32_target", bus.targetAddress_o, 64'h0);
    chk("m32_majid", bus.instMajId_o, 30);
    bus.is64Bit_i = 1'b1;

    // Asynchronous reset mid-run
    bus.ctrWrite_i = 1'b1;  bus.ctrWriteData_i = 64'd5;
    drive_push(64'h7000, mk_body(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b1), 64'd40);
    step();
    bus.ctrWrite_i = 1'b0;
    idle(); step(); step();
    chk("ar_pre_enable", bus.enable_o, 1);
    chk("ar_pre_ctr", bus.ctr_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_enable", bus.enable_o, 0);
    chk("ar_lrwrite", bus.lrWrite_o, 0);
    chk("ar_target", bus.targetAddress_o, 0);
    chk("ar_ctr", bus.ctr_o, 0);
    chk("ar_full", bus.full_o, 0);
    chk("ar_majid", bus.instMajId_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the B-format decoder output interface: accepts decoded B-form conditional branches (bc/bca/bcl/bcla).
- Buffers them in a small FIFO; evaluates BO/BI against CR and an internally owned CTR.
- Computes target and link addresses; emits a resolved-branch record two cycles after dequeue.
- Sits in the back end after decode, feeding fetch redirect and LR writeback.

Parameters:
- addressWidth, 64, instruction/target address width
- instructionCounterWidth, 64, major ID width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- opcodeSize, 12, decoded opcode width
- funcUnitCodeSize, 3, functional-unit code width
- BranchUnitID, 6, functional-unit code accepted by this block
- fifoDepth, 4, input queue entries (power of two, at least 2)

Ports:
- clock_i  in  1  clock, rising edge
- reset_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  decoder output valid
- stall_i  in  1  freeze pipeline and outputs
- flush_i  in  1  discard queue and pipeline contents
- opcode_i  in  12  decoded opcode (passed through)
- functionalUnitType_i  in  3  must equal BranchUnitID to enqueue
- instructionAddress_i  in  64  CIA
- instMajId_i  in  64  major ID
- is64Bit_i  in  1  64-bit mode
- instPid_i  in  20  process ID
- instTid_i  in  16  thread ID
- instructionBody_i  in  28  decoded instruction fields (layout under Behaviour)
- cr_i  in  32  architected CR, bit 0 = MSB
- ctrWrite_i  in  1  mtctr load strobe
- ctrWriteData_i  in  64  CTR load value
- full_o  out  1  FIFO full; decoder must hold
- enable_o  out  1  resolved record valid
- opcode_o  out  12  decoded opcode
- taken_o  out  1  branch taken
- targetAddress_o  out  64  next fetch address
- lrWrite_o  out  1  LR write request
- lrData_o  out  64  CIA+4
- ctr_o  out  64  current CTR
- instMajId_o  out  64  major ID
- instPid_o  out  20  process ID
- instTid_o  out  16  thread ID

Behaviour:
- Body layout: [0:4] BO, [5:9] BI, [10:23] BD, [24] AA, [25] LK, [26:27] zero.
- Enqueue: enable_i & !full_o & functionalUnitType_i==BranchUnitID & !flush_i. Other enables are dropped silently.
- FIFO: circular pointers with an extra wrap bit. full_o is combinational from pointers. A push while full is ignored, with no pointer movement. Simultaneous push and pop on a full FIFO is permitted.
- Stage 1 (S1): pops the head when the FIFO is non-empty and S1 is empty or advancing.
- S1 computes:
  - ctrNext = BO[2] ? ctr : ctr-1.
  - ctrOk = BO[2] | ((ctrNext!=0) ^ BO[3]). In 32-bit mode the compare uses low 32 bits only.
  - condOk = BO[0] | (cr_i[BI]==BO[1]).
  - ext = sign-extend {BD,2'b00} to 64.
  - target = AA ? ext : CIA+ext, taken only if ctrOk & condOk; else CIA+4. Addition wraps modulo 2^64. In 32-bit mode target[0:31]=0.
- Stage 2 (S2) registers the result. Latency: enable_i at edge N, empty FIFO, no stall → enable_o high after edge N+2.
- CTR updates at the S1→S2 transfer when !BO[2].
- ctrWrite_i in the same cycle as an S1 decrement: the written value is the decrement operand, i.e. ctr ← ctrWriteData_i-1.
- ctrWrite_i alone loads; it is accepted during stall.
- lrWrite_o = enable_o & LK; lrData_o = CIA+4 (32-bit mode: high half zero). LR is written whether or not the branch is taken.
- stall_i: S1, S2, and all outputs hold; FIFO still accepts pushes; no CTR decrement.
- flush_i: next edge clears FIFO pointers and S1/S2 valids and drops same-cycle input. CTR is not restored; a decrement already committed stays. Flush overrides stall.
- Reset (async assert): all outputs 0, ctr 0, FIFO empty. full_o=0 during reset.

Optional Feature:
- BRANCH_STATS_EN defined: adds outputs takenCount_o and notTakenCount_o, each 32 bits.
  - Each increments on an enable_o cycle that is not stalled, saturating at all ones.
  - Reset to 0; not cleared by flush.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package: BranchUnitID, body field offsets (BO/BI/BD/AA/LK), regSize=5, immediateSize=14.
- One sub-module: branch_fifo, a parameterised width/depth circular queue with full/empty. Condition/target logic stays in the top level.

Test Plan:
- Reset with reset_i=0 mid-run: all outputs 0 immediately and asynchronously; ctr_o=0.
- Unconditional relative bcl: BO=10100, BD=0x0004, AA=0, LK=1, CIA=0x1000 → after 2 edges: taken=1, target=0x1010, lrWrite=1, lrData=0x1004, ctr unchanged.
- bdnz loop: load CTR=2, BO=10000, BD=0x3FFF (-4), CIA=0x2000.
  - First: taken=1, target=0x1FFC, ctr=1.
  - Second: taken=0, target=0x2004, ctr=0.
- CR test: BO=01100, BI=2.
  - cr_i=0x20000000 → taken=1, target=0x00F0 absolute (AA=1, BD=0x003C).
  - cr_i=0 → taken=0.
- Backpressure: stall_i=1, push 4 branches → full_o=1; fifth is not accepted. Release stall → 4 results in order, major IDs 1..4.
- Flush with 3 queued and 1 in S1 → no enable_o for the next 5 cycles; a new push resolves with latency 2. 32-bit mode: CIA=0xFFFFFFFC, BD=1 → target=0x0000000000000000.
